// File: rtl/opicorv32_pkg.sv
// Shared types for the opicorv32 memory interface.
// Memory FSM states and transfer word-size encodings.
package opicorv32_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE       = 2'd0,
        MEM_READ       = 2'd1,
        MEM_WRITE      = 2'd2,
        MEM_PREFETCHED = 2'd3
    } mem_state_e;

    localparam logic [1:0] WS_WORD = 2'd0;
    localparam logic [1:0] WS_HALF = 2'd1;
    localparam logic [1:0] WS_BYTE = 2'd2;

endpackage

// File: rtl/opicorv32_mem_align.sv
// Store lane replication / byte strobes and load lane
// extraction with zero extension.
module opicorv32_mem_align
    import opicorv32_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_size)
            WS_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = st_lo[1] ? 4'b1100 : 4'b0011;
            end
            WS_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            WS_HALF: begin
                ld_data = {16'h0000, ld_lo[1] ?
                           ld_word[31:16] : ld_word[15:0]};
            end
            WS_BYTE: begin
                ld_data = {24'h000000,
                           ld_word[{ld_lo, 3'b000} +: 8]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/opicorv32_mem_if.sv
// Native memory bus master: launches fetch, load and store
// transfers from IDLE and reports completion to control.
module opicorv32_mem_if
    import opicorv32_pkg::*;
#(
    parameter bit LATCHED_MEM_RDATA = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_do_rinst,
    input  logic        mem_do_prefetch,
    input  logic        mem_do_rdata,
    input  logic        mem_do_wdata,
    input  logic [1:0]  mem_wordsize,
    input  logic [31:0] next_pc,
    input  logic [31:0] reg_op1,
    input  logic [31:0] reg_op2,
    output logic        mem_done,
    output logic [31:0] mem_rdata_word,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    mem_state_e  state_q, state_d;
    logic        xfer;
    logic        launch_i, launch_r, launch_w;
    logic        done_c;
    logic [1:0]  ld_size_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rdata_q;
    logic [31:0] ld_word;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    assign xfer = mem_valid & mem_ready;
    assign mem_done = resetn & done_c;

    always_comb begin
        state_d  = state_q;
        launch_i = 1'b0;
        launch_r = 1'b0;
        launch_w = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_do_rinst | mem_do_prefetch) begin
                    launch_i = 1'b1;
                    state_d  = MEM_READ;
                end else if (mem_do_rdata) begin
                    launch_r = 1'b1;
                    state_d  = MEM_READ;
                end else if (mem_do_wdata) begin
                    launch_w = 1'b1;
                    state_d  = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (xfer) begin
                    done_c  = mem_do_rinst | mem_do_rdata
                            | mem_do_wdata;
                    state_d = (mem_do_rinst | mem_do_rdata) ?
                              MEM_IDLE : MEM_PREFETCHED;
                end
            end
            MEM_WRITE: begin
                if (xfer) begin
                    done_c  = mem_do_rinst | mem_do_rdata
                            | mem_do_wdata;
                    state_d = MEM_IDLE;
                end
            end
            MEM_PREFETCHED: begin
                // A data access pre-empts the parked fetch word.
                if (mem_do_rinst) begin
                    done_c  = 1'b1;
                    state_d = MEM_IDLE;
                end else if (mem_do_rdata | mem_do_wdata) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= MEM_IDLE;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            ld_size_q <= WS_WORD;
            addr_lo_q <= 2'b00;
            rdata_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (launch_i | launch_r | launch_w) begin
                mem_valid <= 1'b1;
            end else if (xfer) begin
                mem_valid <= 1'b0;
            end
            if (launch_i) begin
                mem_instr <= 1'b1;
                mem_addr  <= {next_pc[31:2], 2'b00};
                mem_wstrb <= 4'h0;
                ld_size_q <= WS_WORD;
                addr_lo_q <= next_pc[1:0];
            end
            if (launch_r) begin
                mem_instr <= 1'b0;
                mem_addr  <= {reg_op1[31:2], 2'b00};
                mem_wstrb <= 4'h0;
                ld_size_q <= mem_wordsize;
                addr_lo_q <= reg_op1[1:0];
            end
            if (launch_w) begin
                mem_instr <= 1'b0;
                mem_addr  <= {reg_op1[31:2], 2'b00};
                mem_wdata <= st_wdata;
                mem_wstrb <= st_wstrb;
                ld_size_q <= mem_wordsize;
                addr_lo_q <= reg_op1[1:0];
            end
            if (xfer && state_q == MEM_READ) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    generate
        if (LATCHED_MEM_RDATA) begin : g_bus_held
            assign ld_word = mem_rdata;
        end else begin : g_local_reg
            assign ld_word = xfer ? mem_rdata : rdata_q;
        end
    endgenerate

    opicorv32_mem_align u_align (
        .st_size  (mem_wordsize),
        .st_lo    (reg_op1[1:0]),
        .st_data  (reg_op2),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_size  (ld_size_q),
        .ld_lo    (addr_lo_q),
        .ld_word  (ld_word),
        .ld_data  (mem_rdata_word)
    );

endmodule
